// File: rtl/stream_mux_rr_if.sv
// Handshake bundle for stream_mux_rr: N input channels funnelled into one output stream.
// in_last exists only when STREAM_MUX_LOCK_EN is defined.
interface stream_mux_rr_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4
);
  localparam int SELW = $clog2(N);

  logic             mode;
  logic [SELW-1:0]  sel;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
`ifdef STREAM_MUX_LOCK_EN
  logic [N-1:0]     in_last;
`endif
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [SELW-1:0]  out_src;

  // Valid/ready contract on every channel: a beat moves on a cycle where
  // valid and ready are both high at the rising edge; valid must not depend
  // on ready, and a raised valid holds with stable data until accepted.
`ifdef STREAM_MUX_LOCK_EN
  modport master (
    output mode, sel, in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_src
  );
  modport slave (
    input  mode, sel, in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_src
  );
`else
  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_src
  );
  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_src
  );
`endif
endinterface

// File: rtl/stream_mux_rr.sv
// N:1 stream mux with explicit-select or round-robin arbitration and a registered output.
// Define STREAM_MUX_LOCK_EN to hold the grant on one channel until its in_last beat.
module stream_mux_rr #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input logic           clk,
  input logic           rst,
  stream_mux_rr_if.slave bus
);
  localparam int SELW = $clog2(N);

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SELW-1:0]  out_src_q;
  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  grant;
  logic [SELW-1:0]  next_ptr;
  logic             granted;
  logic             load_en;
  logic             xfer;
  logic [N-1:0]     ready;
  int               idx;
`ifdef STREAM_MUX_LOCK_EN
  logic             locked;
  logic [SELW-1:0]  lock_ch;
`endif

  assign load_en = !out_valid_q || bus.out_ready;

  always_comb begin
    granted = 1'b0;
    grant   = '0;
    idx     = 0;
`ifdef STREAM_MUX_LOCK_EN
    if (locked) begin
      // Mid-packet: only the owning channel may proceed, regardless of mode.
      if (bus.in_valid[lock_ch]) begin
        granted = 1'b1;
        grant   = lock_ch;
      end
    end else
`endif
    if (!bus.mode) begin
      if (int'(bus.sel) < N && bus.in_valid[bus.sel]) begin
        granted = 1'b1;
        grant   = bus.sel;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = (int'(rr_ptr) + k) % N;
        if (!granted && bus.in_valid[idx]) begin
          granted = 1'b1;
          grant   = SELW'(idx);
        end
      end
    end
  end

  assign xfer = load_en && granted;

  always_comb begin
    ready = '0;
    if (xfer) ready[grant] = 1'b1;
  end

  // Explicit wrap keeps the pointer legal when N is not a power of two.
  assign next_ptr = (int'(grant) == N - 1) ? '0 : grant + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr      <= '0;
`ifdef STREAM_MUX_LOCK_EN
      locked      <= 1'b0;
      lock_ch     <= '0;
`endif
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.in_data[int'(grant)*WIDTH +: WIDTH];
      out_src_q   <= grant;
      rr_ptr      <= next_ptr;
`ifdef STREAM_MUX_LOCK_EN
      locked      <= !bus.in_last[grant];
      lock_ch     <= grant;
`endif
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: directed plan followed by randomized traffic.
module tb_stream_mux_rr;
  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SELW  = $clog2(N);

  logic clk;
  logic rst;
  stream_mux_rr_if #(.WIDTH(WIDTH), .N(N)) bus ();

  stream_mux_rr #(.WIDTH(WIDTH), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [SELW+WIDTH-1:0] exp_q[$];
  bit armed  = 0;
  bit m_busy = 0;
  int m_ptr  = 0;
  int m_lock = -1;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference arbitration: which channel the rules say wins this cycle, -1 if none.
  function automatic int pick();
`ifdef STREAM_MUX_LOCK_EN
    if (m_lock >= 0) return bus.in_valid[m_lock] ? m_lock : -1;
`endif
    if (!bus.mode) begin
      if (int'(bus.sel) < N && bus.in_valid[bus.sel]) return int'(bus.sel);
      return -1;
    end
    for (int k = 0; k < N; k++)
      if (bus.in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  // Monitor: compares the presented output beat against the queue head.
  always @(negedge clk) begin
    #1;
    m_busy = 0;
    if (armed) begin
      m_busy = exp_q.size() > 0;
      check("out_valid", int'(bus.out_valid), int'(m_busy));
      if (m_busy && bus.out_valid) begin
        check("out_beat", int'({bus.out_src, bus.out_data}), int'(exp_q[0]));
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Model: predicts acceptance for the coming edge and pushes the expected beat.
  always @(negedge clk) begin
    int g;
    bit load;
    logic [N-1:0] exp_rdy;
    #2;
    if (rst) begin
      exp_q.delete();
      m_ptr  = 0;
      m_lock = -1;
      armed  = 1;
    end else if (armed) begin
      load    = !m_busy || bus.out_ready;
      g       = pick();
      exp_rdy = '0;
      if (load && g >= 0) exp_rdy[g] = 1'b1;
      check("in_ready", int'(bus.in_ready), int'(exp_rdy));
      if (load && g >= 0) begin
        exp_q.push_back({SELW'(g), bus.in_data[g*WIDTH +: WIDTH]});
        m_ptr = (g + 1) % N;
`ifdef STREAM_MUX_LOCK_EN
        m_lock = bus.in_last[g] ? -1 : g;
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input bit md, input int sl, input logic [N-1:0] v,
                      input logic [N-1:0] lst, input bit ordy);
    @(negedge clk);
    bus.mode      = md;
    bus.sel       = SELW'(sl);
    bus.in_valid  = v;
    bus.out_ready = ordy;
`ifdef STREAM_MUX_LOCK_EN
    bus.in_last   = lst;
`else
    if (lst != '0) bus.out_ready = ordy;
`endif
  endtask

  task automatic fixed_data();
    for (int i = 0; i < N; i++) bus.in_data[i*WIDTH +: WIDTH] = WIDTH'(8'h10 * (i + 1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst           = 1'b1;
    bus.mode      = 1'b0;
    bus.sel       = '0;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef STREAM_MUX_LOCK_EN
    bus.in_last   = '0;
`endif

    // Reset state with idle inputs
    do_reset();
    repeat (3) step(0, 0, 4'b0000, 4'b0000, 1);
    #3;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_out_src", int'(bus.out_src), 0);
    check("rst_in_ready", int'(bus.in_ready), 0);

    // Explicit select of channel 2, streaming every cycle
    fixed_data();
    step(0, 2, 4'b1111, 4'b1111, 1);
    #3 check("sel2_in_ready", int'(bus.in_ready), 4'b0100);
    repeat (2) begin
      step(0, 2, 4'b1111, 4'b1111, 1);
      #3;
      check("sel2_data", int'(bus.out_data), 8'h30);
      check("sel2_src", int'(bus.out_src), 2);
    end

    // Round-robin across four busy channels
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1, 0, 4'b1111, 4'b1111, 1);
      #3;
      if (i > 0) check("rr_src", int'(bus.out_src), (i - 1) % N);
    end

    // Backpressure stall, then release hands the next beat to channel 3
    do_reset();
    step(1, 0, 4'b1010, 4'b1111, 1);
    repeat (4) begin
      step(1, 0, 4'b1010, 4'b1111, 0);
      #3;
      check("stall_data", int'(bus.out_data), 8'h20);
      check("stall_in_ready", int'(bus.in_ready), 0);
    end
    step(1, 0, 4'b1010, 4'b1111, 1);
    #3 check("release_in_ready", int'(bus.in_ready), 4'b1000);
    step(1, 0, 4'b0000, 4'b1111, 1);
    #3;
    check("release_src", int'(bus.out_src), 3);
    check("release_data", int'(bus.out_data), 8'h40);

    // Select of an idle channel grants nothing until it raises valid
    do_reset();
    step(0, 3, 4'b0111, 4'b1111, 1);
    #3 check("idle_sel_in_ready", int'(bus.in_ready), 0);
    step(0, 3, 4'b0111, 4'b1111, 1);
    #3 check("idle_sel_out_valid", int'(bus.out_valid), 0);
    step(0, 3, 4'b1111, 4'b1111, 1);
    #3 check("sel3_in_ready", int'(bus.in_ready), 4'b1000);
    step(0, 3, 4'b0000, 4'b1111, 1);
    #3;
    check("sel3_src", int'(bus.out_src), 3);
    check("sel3_data", int'(bus.out_data), 8'h40);

`ifdef STREAM_MUX_LOCK_EN
    // Packet lock, interrupted by reset mid-packet, then a full packet
    do_reset();
    step(1, 0, 4'b0011, 4'b0000, 1);
    step(1, 0, 4'b0011, 4'b0000, 1);
    #3 check("lock_src", int'(bus.out_src), 0);
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = '0;
    @(negedge clk);
    #3 check("lock_rst_out_valid", int'(bus.out_valid), 0);
    rst = 1'b0;
    step(1, 0, 4'b0010, 4'b0000, 1);
    #3 check("lock_cleared", int'(bus.in_ready), 4'b0010);
    step(1, 0, 4'b0011, 4'b0000, 1);
    step(1, 0, 4'b0011, 4'b0000, 1);
    step(1, 0, 4'b0011, 4'b0000, 1);
    step(1, 0, 4'b0011, 4'b0001, 1);
    step(1, 0, 4'b0010, 4'b0000, 1);
    step(1, 0, 4'b0000, 4'b0000, 1);
`endif

    // Randomized traffic with occasional mid-stream resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      step(bit'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
           N'($urandom), N'($urandom), $urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) bus.in_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    end
    step(0, 0, 4'b0000, 4'b0000, 1);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N:1 stream multiplexer; successor to the plain 2:1 combinational mux.
- Per-input valid/ready handshakes and a registered output stage.
- Two selection modes: explicit select, or fair round-robin arbitration.
- Used wherever several producers share one downstream consumer, such as a bus funnel or debug/trace merge.

Parameters:
- WIDTH, 8, data width of each channel in bits.
- N, 4, number of input channels; legal range 2..16.
- SELW, $clog2(N), select/source index width; localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- mode  in  1  0 = explicit select via sel; 1 = round-robin
- sel  in  SELW  channel index used when mode=0
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  N  per-channel valid
- in_ready  out  N  per-channel ready; combinational
- out_data  out  WIDTH  registered output data
- out_valid  out  1  registered output valid
- out_ready  in  1  downstream ready
- out_src  out  SELW  index of the channel that supplied out_data; registered

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_data=0, out_src=0, rr_ptr=0, and lock state cleared if present. rst overrides all other activity, including mid-transfer; a held beat is discarded.
- load_en = !out_valid || out_ready. The output register accepts a beat only when load_en=1.
- Grant, mode=0: grant=sel when sel<N and in_valid[sel]=1; otherwise no grant. sel>=N never grants.
- Grant, mode=1:
  - Search order is rr_ptr, rr_ptr+1, ..., rr_ptr+N-1 (mod N).
  - The first channel with in_valid=1 is granted.
- in_ready[i] = load_en && granted && grant==i. At most one in_ready bit is high in any cycle.
- Transfer on channel i when in_valid[i] && in_ready[i]. At the next edge: out_data<=channel i data, out_src<=i, out_valid<=1.
- Drain: out_valid && out_ready with no new transfer gives out_valid<=0. out_data and out_src keep their last values.
- Simultaneous drain and load in the same cycle is allowed. This gives full throughput of one beat per cycle.
- Latency: one cycle from input transfer to out_valid.
- Stall: while out_valid=1 and out_ready=0:
  - out_data and out_src are stable;
  - all in_ready bits are 0.
- rr_ptr update:
  - After a transfer, in either mode, rr_ptr<=(grant+1) mod N. Wrap from N-1 to 0; correct for non-power-of-two N.
  - rr_ptr is unchanged when there is no transfer.
- mode and sel are sampled combinationally each cycle. A change affects only the next grant, never a beat already held.
- Handshake contract on inputs: once in_valid[i] is asserted, it is expected to stay high with stable data until accepted. The block does not enforce this.

Optional Feature:
- Macro: STREAM_MUX_LOCK_EN.
- When defined:
  - Adds input port in_last (width N), marking the final beat of a packet.
  - After a transfer from channel i with in_last[i]=0, the grant is locked to channel i, whatever mode, sel or other valids are.
  - The lock releases after the transfer with in_last[i]=1; rr_ptr then updates to i+1 mod N.
  - While locked and in_valid[i]=0, nothing is granted.
  - rst clears the lock.
- When undefined: the in_last port is absent and arbitration is per beat.

Test Plan (N=4, WIDTH=8):
- Reset, then hold out_ready=1 for 3 cycles with no valids -> out_valid=0, out_data=0x00, out_src=0, in_ready=4'b0000.
- mode=0, sel=2, in_valid=4'b1111, data ch0..3 = 0x10/0x20/0x30/0x40, out_ready=1 -> in_ready=4'b0100; next cycle out_data=0x30, out_src=2, out_valid=1; repeats 0x30 every cycle.
- mode=1, all four channels valid continuously, out_ready=1 -> out_src sequence 0,1,2,3,0,1 on consecutive cycles, one beat per cycle.
- mode=1, ch1 and ch3 valid, out_ready held 0 for 4 cycles after the first beat -> out_data frozen at ch1 value, in_ready=0 throughout; on release the next beat has out_src=3.
- mode=0, sel=3'd... (SELW=2) with sel=3 and in_valid[3]=0 -> no grant, out_valid stays 0; then raise in_valid[3] -> beat from ch3 appears one cycle later.
- With STREAM_MUX_LOCK_EN, mode=1, ch0 sends a 3-beat packet (in_last on beat 3) while ch1 is valid throughout -> out_src=0,0,0 then 1; assert rst after beat 2 -> out_valid=0 next cycle and the lock is cleared.
